gtxe2_chnl_rx_sync_ctrl: RTL
============================

Name: gtxe2_chnl_rx_sync_ctrl

Overview:
- Word-sync controller for the GTXE2 channel receive path; sits beside the comma aligner and sequences it.
- Drives the aligner's comma-align and comma-detect enables, and qualifies commas and decoder errors.
- Declares byte/word sync, freezes alignment while in sync, and re-hunts on loss of sync or electrical idle.
- Processes one received word per clk.

Parameters:
- COMMA_ACQ, 3: consecutive aligned commas required to declare sync (1..15).
- ACQ_TIMEOUT, 1023: cycles allowed in ACQ without a comma before returning to HUNT (1..65535).
- ERR_LIMIT, 4: error-counter value that forces loss of sync (1..7).
- GOOD_RUN, 4: consecutive error-free words that decrement the error counter (1..255).
- PCOMMA_EN, 1: drive rxpcommaalignen during HUNT/ACQ.
- MCOMMA_EN, 1: drive rxmcommaalignen during HUNT/ACQ.

Ports:
- clk  in  1  receive word clock.
- rst  in  1  asynchronous, active-high reset.
- align_en  in  1  software enable; 0 forces IDLE.
- rxelecidle  in  1  electrical idle from the OOB/analog front end.
- rxcommadet  in  1  comma detected this word (from the aligner).
- rxbyteisaligned  in  1  aligner reports it holds an alignment.
- rxbyterealign  in  1  aligner moved its alignment pointer this word.
- word_err  in  1  decoder not-in-table OR disparity error for this word.
- rxcommadeten  out  1  comma-detect enable to the aligner.
- rxpcommaalignen  out  1  P-comma align enable.
- rxmcommaalignen  out  1  M-comma align enable.
- sync_ok  out  1  link word-synchronised.
- sync_lost  out  1  one-cycle pulse on SYNC->HUNT.
- loss_cnt  out  8  saturating count of sync losses.
- state  out  2  current state: IDLE=0, HUNT=1, ACQ=2, SYNC=3.

Behaviour:
- Reset (asynchronous, active-high) puts the block in IDLE and clears every counter.
  - All outputs read 0 while rst is high.
  - rst asserted mid-operation aborts immediately; no sync_lost pulse is produced.
- All outputs are registered (Moore). An input seen at edge N affects outputs after edge N, i.e. one-cycle latency.
- Global priority, highest first: rst > (rxelecidle | ~align_en) -> IDLE > per-state rules.
  - Leaving SYNC through this path gives no sync_lost pulse and no loss_cnt increment.
- IDLE:
  - All enables 0, sync_ok 0, counters cleared.
  - Goes to HUNT when align_en=1 and rxelecidle=0.
- HUNT:
  - rxcommadeten=1; rxpcommaalignen=PCOMMA_EN; rxmcommaalignen=MCOMMA_EN.
  - rxcommadet & rxbyteisaligned -> ACQ, with comma_cnt=1 and tmo_cnt=0.
  - word_err is ignored in HUNT.
- ACQ:
  - Same enables as HUNT; tmo_cnt increments every cycle.
  - Per-cycle rules, evaluated in order:
    1. word_err -> HUNT.
    2. rxbyterealign -> comma_cnt=1, tmo_cnt=0 (stay in ACQ).
    3. rxcommadet -> comma_cnt+1 and tmo_cnt=0; when comma_cnt+1 == COMMA_ACQ -> SYNC.
    4. tmo_cnt == ACQ_TIMEOUT-1 with no comma -> HUNT.
  - COMMA_ACQ=1: the HUNT->ACQ comma is enough, so the block goes HUNT->SYNC directly.
- SYNC:
  - rxcommadeten=1; both align enables 0 (alignment frozen); sync_ok=1.
  - Error counting:
    - word_err: err_cnt+1 and good_cnt cleared.
    - Otherwise good_cnt+1; at GOOD_RUN, good_cnt resets and err_cnt decrements, floored at 0.
  - err_cnt reaching ERR_LIMIT -> HUNT.
  - rxbyterealign while in SYNC -> HUNT immediately (unexpected pointer move).
  - Every SYNC->HUNT transition pulses sync_lost for 1 cycle and increments loss_cnt, saturating at 255.
- Simultaneous events:
  - word_err together with rxcommadet in ACQ resolves as word_err (HUNT).
  - word_err together with rxbyterealign in SYNC gives a single loss event.
- Counter widths:
  - comma_cnt 4b, err_cnt 3b, good_cnt 8b, tmo_cnt 16b.
  - tmo_cnt never wraps, because reaching ACQ_TIMEOUT-1 forces an exit.

Decomposition:
- Package gtxe2_chnl_rx_sync_pkg holds:
  - state encoding constants IDLE/HUNT/ACQ/SYNC;
  - counter-width constants.
- Sub-module gtxe2_chnl_rx_sync_errmon: the SYNC-state err_cnt/good_cnt monitor. Inputs are enable, clear and word_err; output is limit_hit.
- FSM, timeout and loss_cnt stay in the top module.

Test Plan:
- Reset and idle:
  - Stimulus: rst high; then rst low with align_en=1, rxelecidle=0.
  - Required: all outputs 0 during reset; state=1 (HUNT) one cycle after rst falls; rxpcommaalignen=rxmcommaalignen=1.
- Acquire:
  - Stimulus: COMMA_ACQ=3; rxcommadet with rxbyteisaligned on 3 separate cycles, no errors.
  - Required: state 1->2->3; sync_ok=1 and both align enables 0 on the cycle after the 3rd comma.
- Lose sync:
  - Stimulus: in SYNC, 4 word_err with fewer than 4 clean words between them.
  - Required: state->1; sync_lost high for exactly 1 cycle; loss_cnt=1.
  - Stimulus: 3 errors each separated by 4 clean words.
  - Required: stays in SYNC; err_cnt ends at 1.
- Timeout:
  - Stimulus: ACQ_TIMEOUT=16; one comma, then silence.
  - Required: returns to HUNT 16 cycles after entering ACQ; no sync_lost pulse.
- Priority:
  - Stimulus: in SYNC, rxelecidle=1 on the same cycle as word_err.
  - Required: state->0; sync_lost=0; loss_cnt unchanged.
- Realign in SYNC, then async reset:
  - Stimulus: in SYNC, rxbyterealign for 1 cycle.
  - Required: state->1 and sync_lost pulse.
  - Stimulus: rst asserted mid-cycle.
  - Required: outputs clear before the next clk edge.

Source files
------------

// File: rtl/gtxe2_chnl_rx_sync_pkg.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_sync_pkg
// Shared definitions for the GTXE2 RX word-sync controller.
//   sync_state_e : controller state encoding as seen on the state output
//   *_W          : counter widths used by the controller and its error monitor
// ---------------------------------------------------------------------------
package gtxe2_chnl_rx_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_ACQ  = 2'd2,
        ST_SYNC = 2'd3
    } sync_state_e;

    localparam int COMMA_W = 4;   // consecutive aligned commas in ACQ
    localparam int ERR_W   = 3;   // weighted error count in SYNC
    localparam int GOOD_W  = 8;   // clean-word run length in SYNC
    localparam int TMO_W   = 16;  // comma-less cycles in ACQ
    localparam int LOSS_W  = 8;   // saturating sync-loss counter

endpackage

// File: rtl/gtxe2_chnl_rx_sync_ctrl_if.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_sync_ctrl_if
// Bundle between the comma aligner / decoder side and the word-sync controller.
//   Aligner -> controller : align_en, rxelecidle, rxcommadet, rxbyteisaligned,
//                           rxbyterealign, word_err
//   Controller -> aligner : rxcommadeten, rxpcommaalignen, rxmcommaalignen
//   Controller status     : sync_ok, sync_lost, loss_cnt, state
// master = the side that drives the aligner inputs; slave = the controller.
// ---------------------------------------------------------------------------
interface gtxe2_chnl_rx_sync_ctrl_if;
    import gtxe2_chnl_rx_sync_pkg::*;

    logic              align_en;
    logic              rxelecidle;
    logic              rxcommadet;
    logic              rxbyteisaligned;
    logic              rxbyterealign;
    logic              word_err;

    logic              rxcommadeten;
    logic              rxpcommaalignen;
    logic              rxmcommaalignen;
    logic              sync_ok;
    logic              sync_lost;
    logic [LOSS_W-1:0] loss_cnt;
    logic [1:0]        state;

    modport master (
        output align_en, rxelecidle, rxcommadet, rxbyteisaligned, rxbyterealign, word_err,
        input  rxcommadeten, rxpcommaalignen, rxmcommaalignen, sync_ok, sync_lost,
               loss_cnt, state
    );

    modport slave (
        input  align_en, rxelecidle, rxcommadet, rxbyteisaligned, rxbyterealign, word_err,
        output rxcommadeten, rxpcommaalignen, rxmcommaalignen, sync_ok, sync_lost,
               loss_cnt, state
    );
endinterface

// File: rtl/gtxe2_chnl_rx_sync_errmon.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_sync_errmon
// Error-rate monitor used while the link is in SYNC. Each bad word adds one to
// the error count; every GOOD_RUN consecutive clean words remove one (floor 0).
//   clk, rst     : word clock, async active-high reset
//   i_enable     : count this word (controller is in SYNC)
//   i_clear      : hold both counters at zero (controller is not in SYNC)
//   i_word_err   : decoder error on this word
//   o_limit_hit  : this word takes the error count to ERR_LIMIT
// ---------------------------------------------------------------------------
module gtxe2_chnl_rx_sync_errmon
    import gtxe2_chnl_rx_sync_pkg::*;
#(
    parameter int ERR_LIMIT = 4,
    parameter int GOOD_RUN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    input  logic i_word_err,
    output logic o_limit_hit
);
    localparam logic [ERR_W-1:0]  ERR_LIMIT_C = ERR_W'(ERR_LIMIT);
    localparam logic [GOOD_W-1:0] GOOD_RUN_C  = GOOD_W'(GOOD_RUN);

    logic [ERR_W-1:0]  r_err_cnt;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [ERR_W-1:0]  w_err_inc;
    logic [GOOD_W-1:0] w_good_inc;

    assign w_err_inc  = r_err_cnt + ERR_W'(1);
    assign w_good_inc = r_good_cnt + GOOD_W'(1);

    // Decided from the current word so the controller leaves SYNC on the same
    // edge that records the limiting error.
    assign o_limit_hit = i_enable && !i_clear && i_word_err && (w_err_inc == ERR_LIMIT_C);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt  <= '0;
            r_good_cnt <= '0;
        end else if (i_clear) begin
            r_err_cnt  <= '0;
            r_good_cnt <= '0;
        end else if (i_enable) begin
            if (i_word_err) begin
                r_err_cnt  <= w_err_inc;
                r_good_cnt <= '0;
            end else if (w_good_inc == GOOD_RUN_C) begin
                r_good_cnt <= '0;
                if (r_err_cnt != '0) begin
                    r_err_cnt <= r_err_cnt - ERR_W'(1);
                end
            end else begin
                r_good_cnt <= w_good_inc;
            end
        end
    end
endmodule

// File: rtl/gtxe2_chnl_rx_sync_ctrl.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_sync_ctrl
// Word-sync controller for the GTXE2 RX path. Hunts for an aligned comma,
// confirms COMMA_ACQ commas, then freezes the aligner and watches the error
// rate; re-hunts on too many errors or an unexpected realign.
//   clk, rst : receive word clock, async active-high reset
//   sif      : slave side of gtxe2_chnl_rx_sync_ctrl_if (aligner inputs,
//              aligner enables, sync status, loss counter, state)
// All outputs are decoded from registers (Moore, one-cycle latency).
// ---------------------------------------------------------------------------
module gtxe2_chnl_rx_sync_ctrl
    import gtxe2_chnl_rx_sync_pkg::*;
#(
    parameter int COMMA_ACQ   = 3,
    parameter int ACQ_TIMEOUT = 1023,
    parameter int ERR_LIMIT   = 4,
    parameter int GOOD_RUN    = 4,
    parameter bit PCOMMA_EN   = 1'b1,
    parameter bit MCOMMA_EN   = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    gtxe2_chnl_rx_sync_ctrl_if.slave sif
);
    localparam logic [COMMA_W-1:0] COMMA_ACQ_C = COMMA_W'(COMMA_ACQ);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(ACQ_TIMEOUT - 1);
    localparam logic [LOSS_W-1:0]  LOSS_MAX    = '1;

    sync_state_e        r_state, w_state_nxt;
    logic [COMMA_W-1:0] r_comma_cnt, w_comma_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_nxt;
    logic [LOSS_W-1:0]  r_loss_cnt;
    logic               r_sync_lost;
    logic               w_in_sync, w_aligning, w_limit_hit, w_loss_evt;

    assign w_in_sync  = (r_state == ST_SYNC);
    assign w_aligning = (r_state == ST_HUNT) || (r_state == ST_ACQ);

    gtxe2_chnl_rx_sync_errmon #(
        .ERR_LIMIT (ERR_LIMIT),
        .GOOD_RUN  (GOOD_RUN)
    ) u_errmon (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (w_in_sync),
        .i_clear     (!w_in_sync),
        .i_word_err  (sif.word_err),
        .o_limit_hit (w_limit_hit)
    );

    // NOTE: every signal written here gets a default first; without it a
    // path that skips an assignment would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_comma_nxt = r_comma_cnt;
        w_tmo_nxt   = r_tmo_cnt;

        if (sif.rxelecidle || !sif.align_en) begin
            w_state_nxt = ST_IDLE;
            w_comma_nxt = '0;
            w_tmo_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_HUNT;
                    w_comma_nxt = '0;
                    w_tmo_nxt   = '0;
                end
                ST_HUNT: begin
                    if (sif.rxcommadet && sif.rxbyteisaligned) begin
                        w_comma_nxt = COMMA_W'(1);
                        w_tmo_nxt   = '0;
                        // A single-comma requirement is met by the hunting comma.
                        w_state_nxt = (COMMA_ACQ_C == COMMA_W'(1)) ? ST_SYNC : ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
                    if (sif.word_err) begin
                        w_state_nxt = ST_HUNT;
                    end else if (sif.rxbyterealign) begin
                        // Pointer moved: earlier commas no longer vouch for it.
                        w_comma_nxt = COMMA_W'(1);
                        w_tmo_nxt   = '0;
                    end else if (sif.rxcommadet) begin
                        w_comma_nxt = r_comma_cnt + COMMA_W'(1);
                        w_tmo_nxt   = '0;
                        if (w_comma_nxt == COMMA_ACQ_C) begin
                            w_state_nxt = ST_SYNC;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                ST_SYNC: begin
                    if (sif.rxbyterealign || w_limit_hit) begin
                        w_state_nxt = ST_HUNT;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Only a SYNC->HUNT move is a loss; the idle path out of SYNC is not.
    assign w_loss_evt = w_in_sync && (w_state_nxt == ST_HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_comma_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_sync_lost <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_comma_cnt <= w_comma_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_sync_lost <= w_loss_evt;
            if (w_loss_evt && (r_loss_cnt != LOSS_MAX)) begin
                r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
            end
        end
    end

    assign sif.rxcommadeten    = (r_state != ST_IDLE);
    assign sif.rxpcommaalignen = PCOMMA_EN && w_aligning;
    assign sif.rxmcommaalignen = MCOMMA_EN && w_aligning;
    assign sif.sync_ok         = w_in_sync;
    assign sif.sync_lost       = r_sync_lost;
    assign sif.loss_cnt        = r_loss_cnt;
    assign sif.state           = r_state;
endmodule
